axilite_cfg_slave: RTL and testbench
====================================

# axilite_cfg_slave

AXI-Lite responder that terminates the Wishbone-to-AXI-Lite bridge's write and read channels for the FIR engine. Provides the engine's configuration space: control/status register, data-length register, and a single-port tap-coefficient RAM port. Sits between the bridge's AXI-Lite initiator ports and the FIR datapath/tap RAM, in the `clk` domain.

## Interface

- `pADDR_WIDTH`, 12: AXI-Lite address width.
- `pDATA_WIDTH`, 32: data width.
- `Tape_Num`, 11: number of tap coefficients.

- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `awvalid` in 1 / `awready` out 1 / `awaddr` in pADDR_WIDTH: write address channel.
- `wvalid` in 1 / `wready` out 1 / `wdata` in pDATA_WIDTH: write data channel; the `wready` pulse is the write acknowledge. There is no B channel.
- `arvalid` in 1 / `arready` out 1 / `araddr` in pADDR_WIDTH: read address channel.
- `rvalid` out 1 / `rready` in 1 / `rdata` out pDATA_WIDTH: read data channel.
- `ap_start` out 1: one-cycle start pulse to the engine.
- `ap_done_i` in 1: one-cycle completion pulse from the engine.
- `data_length` out pDATA_WIDTH: sample count register.
- `tap_EN` out 1, `tap_WE` out 4, `tap_A` out pADDR_WIDTH, `tap_Di` out pDATA_WIDTH, `tap_Do` in pDATA_WIDTH: tap RAM port; read data is valid one cycle after the address.

## Operation

- Register map (byte addresses):
  - 0x00 `ap_ctrl`: bit0 start (W1), bit1 done (RO, sticky), bit2 idle (RO).
  - 0x10 `data_length` (RW).
  - 0x20 + 4k, k < Tape_Num: tap k; `tap_A` = addr − 0x20.
  - Other addresses: writes are dropped; reads return 0.
- Write FSM: W_IDLE → W_ACK → W_WAIT → W_IDLE.
  - W_IDLE → W_ACK when `awvalid` and `wvalid` are both high.
  - W_ACK lasts one cycle. `awready` and `wready` are high and the commit happens in this cycle.
  - W_WAIT is left when `awvalid` and `wvalid` are both low (see Configuration).
- Read FSM: R_IDLE → R_ADDR → R_MEM → R_DATA → R_WAIT → R_IDLE.
  - In R_ADDR, `arready` = 1 and the tap RAM is addressed.
  - In R_MEM, `rdata` is captured.
  - R_DATA holds `rvalid` until `rready`.
  - R_WAIT is left when `arvalid` is low.
- Writing 1 to start while idle: `ap_start` pulses, then idle = 0. Writing start while busy is ignored.
- `ap_done_i` sets done and idle.
  - A read of 0x00 returns the current bits, then clears done.
  - If set and clear happen in the same cycle, set wins.
- Tap or `data_length` access while not idle:
  - Writes are acknowledged but dropped.
  - Reads return 0xFFFFFFFF.
- Tap write: `tap_EN` = 1, `tap_WE` = 4'hF, `tap_Di` = `wdata`.
- Tap RAM conflict: if W_IDLE→W_ACK and R_IDLE→R_ADDR both target the RAM in the same cycle, the write wins and the read waits one cycle in R_IDLE.

## Timing

- Reset values:
  - All outputs are 0: `awready`, `wready`, `arready`, `rvalid`, `rdata`, `ap_start`, `data_length`, `tap_*`.
  - Internal state: idle = 1, done = 0, both FSMs in IDLE.
- Write: valids sampled high at edge T → `awready` = `wready` = 1 during cycle T+1 (exactly one cycle). The register or RAM write occurs at the end of T+1.
- Read: `arvalid` sampled at T → `arready` high during T+1 → `rvalid` high from T+3 with stable `rdata` until the `rready` handshake.
- `ap_start` goes high in the cycle after the W_ACK that wrote start. Idle drops on the same edge.
- Reset mid-transaction aborts both FSMs immediately, with no partial commit beyond an already completed W_ACK.

## Configuration

- `AXIL_VALID_DROP_EN` defined:
  - W_WAIT and R_WAIT stay in place until the relevant valid(s) deassert.
  - This absorbs the bridge's registered valids, which stay high one or more cycles after the handshake.
- Undefined:
  - Strict AXI-Lite. W_WAIT and R_WAIT each last exactly one cycle, then go to IDLE.
  - Valids still high are treated as a new transaction.

## Structure

- Package `axilite_cfg_pkg`:
  - Address constants: ADDR_AP_CTRL, ADDR_DATA_LEN, ADDR_TAP_BASE.
  - Bit indices: AP_START, AP_DONE, AP_IDLE.
  - Write/read FSM state encodings.
  - BUSY_RDATA = 0xFFFFFFFF.
- Sub-module `ap_ctrl_reg`: start/done/idle flags, start pulse generation, and the read-clear of done with set priority.

## Test plan

- Write 0x10 = 0x00000258 (valids held 2 cycles after `wready`, macro on) → one `wready` pulse, `data_length` = 0x258, no second commit.
- Write taps 0x20..0x48 with values 1..11, then read them back → `rdata` = 1..11, each `rvalid` 3 cycles after `arvalid`.
- Write 0x00 = 1 → `ap_start` pulse; read 0x00 → 0x0. Pulse `ap_done_i`, read 0x00 → 0x6, read again → 0x4.
- While busy, write tap 0x24 = 0x55 and read 0x24 → `wready` pulses, RAM unchanged, read returns 0xFFFFFFFF.
- Issue a tap write and a tap read in the same cycle → the write commits first, `arready` is delayed one cycle, and the read returns the new value.
- Assert `rst_n` low during R_DATA → `rvalid` = 0 and idle = 1 immediately; the next read completes normally.

Source files
------------

// File: rtl/axilite_cfg_pkg.sv
// Shared constants and FSM encodings for the FIR engine's AXI-Lite configuration responder.
package axilite_cfg_pkg;

  localparam int unsigned ADDR_AP_CTRL  = 32'h000;
  localparam int unsigned ADDR_DATA_LEN = 32'h010;
  localparam int unsigned ADDR_TAP_BASE = 32'h020;

  localparam int AP_START = 0;
  localparam int AP_DONE  = 1;
  localparam int AP_IDLE  = 2;

  localparam logic [31:0] BUSY_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ACK  = 2'd1,
    W_WAIT = 2'd2
  } w_state_t;

  typedef enum logic [2:0] {
    R_IDLE = 3'd0,
    R_ADDR = 3'd1,
    R_MEM  = 3'd2,
    R_DATA = 3'd3,
    R_WAIT = 3'd4
  } r_state_t;

endpackage

// File: rtl/ap_ctrl_reg.sv
// Engine handshake flags: start pulse, sticky done (cleared by a status read) and idle.
module ap_ctrl_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic start_req,
  input  logic done_set,
  input  logic done_clr,
  output logic ap_start,
  output logic done,
  output logic idle
);

  logic start_ok;

  assign start_ok = start_req && idle;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ap_start <= 1'b0;
      done     <= 1'b0;
      idle     <= 1'b1;
    end else begin
      ap_start <= start_ok;
      if (start_ok) idle <= 1'b0;
      // A completion in the same cycle as a status read must not be lost.
      if (done_set) begin
        done <= 1'b1;
        idle <= 1'b1;
      end else if (done_clr) begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axilite_cfg_slave.sv
// AXI-Lite configuration responder for the FIR engine (ap_ctrl, data_length, tap RAM port).
// Define AXIL_VALID_DROP_EN to hold W_WAIT/R_WAIT until the bridge drops its valids.
module axilite_cfg_slave
  import axilite_cfg_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   ap_start,
  input  logic                   ap_done_i,
  output logic [pDATA_WIDTH-1:0] data_length,
  output logic                   tap_EN,
  output logic [3:0]             tap_WE,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  localparam logic [pADDR_WIDTH-1:0] A_CTRL = pADDR_WIDTH'(ADDR_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] A_LEN  = pADDR_WIDTH'(ADDR_DATA_LEN);
  localparam logic [pADDR_WIDTH-1:0] A_TLO  = pADDR_WIDTH'(ADDR_TAP_BASE);
  localparam logic [pADDR_WIDTH-1:0] A_THI  = pADDR_WIDTH'(ADDR_TAP_BASE + 4 * Tape_Num);

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                   idle, done;
  logic                   aw_tap, ar_tap, rd_tap;
  logic                   w_go, w_ack, ram_clash, start_req, rd_clr, rd_busy;
  logic [pADDR_WIDTH-1:0] rd_addr;
  logic [pDATA_WIDTH-1:0] rd_mux;

  assign aw_tap = (awaddr >= A_TLO) && (awaddr < A_THI);
  assign ar_tap = (araddr >= A_TLO) && (araddr < A_THI);
  assign rd_tap = (rd_addr >= A_TLO) && (rd_addr < A_THI);

  assign w_go      = (w_state == W_IDLE) && awvalid && wvalid;
  assign w_ack     = (w_state == W_ACK);
  // The RAM has one port: a write entering W_ACK holds a tap read back for a cycle.
  assign ram_clash = w_go && aw_tap && arvalid && ar_tap;
  assign start_req = w_ack && (awaddr == A_CTRL) && wdata[AP_START];
  assign rd_clr    = (r_state == R_MEM) && (rd_addr == A_CTRL);

  assign awready = w_ack;
  assign wready  = w_ack;
  assign arready = (r_state == R_ADDR);
  assign rvalid  = (r_state == R_DATA);

  ap_ctrl_reg u_ap_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_req(start_req),
    .done_set (ap_done_i),
    .done_clr (rd_clr),
    .ap_start (ap_start),
    .done     (done),
    .idle     (idle)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (w_go) w_next = W_ACK;
      W_ACK:  w_next = W_WAIT;
`ifdef AXIL_VALID_DROP_EN
      W_WAIT: if (!awvalid && !wvalid) w_next = W_IDLE;
`else
      W_WAIT: w_next = W_IDLE;
`endif
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (arvalid && !ram_clash) r_next = R_ADDR;
      R_ADDR: r_next = R_MEM;
      R_MEM:  r_next = R_DATA;
      R_DATA: if (rready) r_next = R_WAIT;
`ifdef AXIL_VALID_DROP_EN
      R_WAIT: if (!arvalid) r_next = R_IDLE;
`else
      R_WAIT: r_next = R_IDLE;
`endif
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (w_ack && aw_tap && idle) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = awaddr - A_TLO;
      tap_Di = wdata;
    end else if ((r_state == R_ADDR) && ar_tap && idle) begin
      tap_EN = 1'b1;
      tap_A  = araddr - A_TLO;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (rd_addr == A_CTRL) begin
      rd_mux[AP_DONE] = done;
      rd_mux[AP_IDLE] = idle;
    end else if (rd_addr == A_LEN) begin
      rd_mux = rd_busy ? pDATA_WIDTH'(BUSY_RDATA) : data_length;
    end else if (rd_tap) begin
      rd_mux = rd_busy ? pDATA_WIDTH'(BUSY_RDATA) : tap_Do;
    end
  end

  // The busy decision is frozen with the address so it matches what the RAM was asked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_length <= '0;
      rdata       <= '0;
      rd_addr     <= '0;
      rd_busy     <= 1'b0;
    end else begin
      if (w_ack && (awaddr == A_LEN) && idle) data_length <= wdata;
      if (r_state == R_ADDR) begin
        rd_addr <= araddr;
        rd_busy <= !idle;
      end
      if (r_state == R_MEM) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_axilite_cfg_slave.sv
// Randomized self-checking bench for axilite_cfg_slave against a register-map reference model.
module tb_axilite_cfg_slave;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic          awready, wready, arready, rvalid;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [DW-1:0] wdata = '0, rdata;
  logic          ap_start, ap_done_i = 1'b0;
  logic [DW-1:0] data_length;
  logic          tap_EN;
  logic [3:0]    tap_WE;
  logic [AW-1:0] tap_A;
  logic [DW-1:0] tap_Di, tap_Do = '0;

  int checks = 0;
  int errors = 0;
  int start_seen = 0;

  // Reference model state
  logic [31:0] m_len = '0;
  logic [31:0] m_taps [NT];
  logic        m_idle = 1'b1;
  logic        m_done = 1'b0;

  // External single-port tap RAM, read data one cycle after the address
  logic [31:0] ram [NT];

  axilite_cfg_slave #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ap_start(ap_start), .ap_done_i(ap_done_i), .data_length(data_length),
    .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_A(tap_A), .tap_Di(tap_Di), .tap_Do(tap_Do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ap_start) start_seen++;
    if (tap_EN) begin
      if (tap_WE == 4'hF && int'(tap_A[AW-1:2]) < NT) ram[tap_A[AW-1:2]] <= tap_Di;
      tap_Do <= (int'(tap_A[AW-1:2]) < NT) ? ram[tap_A[AW-1:2]] : 32'hDEAD_BEEF;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic bit is_tap(input logic [AW-1:0] a);
    return (int'(a) >= 'h20) && (int'(a) < 'h20 + 4 * NT);
  endfunction

  function automatic bit model_write(input logic [AW-1:0] a, input logic [31:0] d);
    if (a == 12'h000) begin
      if (d[0] && m_idle) begin
        m_idle = 1'b0;
        return 1'b1;
      end
    end else if (a == 12'h010) begin
      if (m_idle) m_len = d;
    end else if (is_tap(a)) begin
      if (m_idle) m_taps[(int'(a) - 'h20) / 4] = d;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a == 12'h000) begin
      v = {29'd0, m_idle, m_done, 1'b0};
      m_done = 1'b0;
    end else if (a == 12'h010) begin
      v = m_idle ? m_len : 32'hFFFF_FFFF;
    end else if (is_tap(a)) begin
      v = m_idle ? m_taps[(int'(a) - 'h20) / 4] : 32'hFFFF_FFFF;
    end
    return v;
  endfunction

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic exp_start,
                           output int lat);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!wready && lat < 20);
    if (!wready) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h: no wready within %0d cycles", a, lat);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (wready !== 1'b0) begin
      errors++; $display("FAIL wready_pulse addr=%h: wready=%b, expected 0", a, wready);
    end
    checks++;
    if (ap_start !== exp_start) begin
      errors++; $display("FAIL ap_start addr=%h: ap_start=%b, expected %b", a, ap_start, exp_start);
    end
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output int lat);
    araddr = a; arvalid = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!arready && lat < 20);
    @(posedge clk); #1; lat++;
    arvalid = 1'b0;
    while (!rvalid && lat < 25) begin @(posedge clk); #1; lat++; end
    if (!rvalid) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h: no rvalid within %0d cycles", a, lat);
    end
    d = rdata;
    repeat ($urandom_range(2)) begin
      @(posedge clk); #1;
      checks++;
      if (rvalid !== 1'b1 || rdata !== d) begin
        errors++;
        $display("FAIL rdata_hold addr=%h: rvalid=%b rdata=%h, expected 1 and %h", a, rvalid, rdata, d);
      end
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL rvalid_drop addr=%h: rvalid=%b, expected 0", a, rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    int lat;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({awready, wready, arready, rvalid, ap_start, tap_EN} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: aw/w/ar/rvalid/start/en=%b, expected 000000",
               {awready, wready, arready, rvalid, ap_start, tap_EN});
    end
    checks++;
    if (rdata !== '0 || data_length !== '0) begin
      errors++; $display("FAIL reset_data: rdata=%h data_length=%h, expected 0", rdata, data_length);
    end
    checks++;
    if (tap_WE !== 4'h0 || tap_A !== '0 || tap_Di !== '0) begin
      errors++; $display("FAIL reset_tap: WE=%h A=%h Di=%h, expected 0", tap_WE, tap_A, tap_Di);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    e = model_read(12'h000);
    axi_read(12'h000, d, lat);
    checks++;
    if (d !== e || lat != 3) begin
      errors++; $display("FAIL reset_status: rdata=%h lat=%0d, expected %h lat=3", d, lat, e);
    end
  endtask

`ifdef AXIL_VALID_DROP_EN
  task automatic test_hold_valids();
    int pulses;
    pulses = 0;
    awaddr = 12'h010; wdata = 32'h258; awvalid = 1'b1; wvalid = 1'b1;
    void'(model_write(12'h010, 32'h258));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (wready) pulses++;
      if (i == 2) begin awvalid = 1'b0; wvalid = 1'b0; end
    end
    checks++;
    if (pulses != 1 || data_length !== m_len) begin
      errors++;
      $display("FAIL hold_valids: wready pulses=%0d data_length=%h, expected 1 and %h",
               pulses, data_length, m_len);
    end
  endtask
`endif

  task automatic test_data_length();
    logic [31:0] v, d, e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 32'h258 : $urandom;
      axi_write(12'h010, v, model_write(12'h010, v), lat);
      checks++;
      if (lat != 1 || data_length !== m_len) begin
        errors++;
        $display("FAIL len_write: lat=%0d data_length=%h, expected 1 and %h", lat, data_length, m_len);
      end
      e = model_read(12'h010);
      axi_read(12'h010, d, lat);
      checks++;
      if (d !== e) begin
        errors++; $display("FAIL len_read: rdata=%h, expected %h", d, e);
      end
    end
  endtask

  task automatic test_taps();
    logic [31:0] d, e;
    logic [AW-1:0] a;
    int lat;
    for (int k = 0; k < NT; k++) begin
      a = AW'('h20 + 4 * k);
      axi_write(a, 32'(k + 1), model_write(a, 32'(k + 1)), lat);
    end
    for (int k = 0; k < NT; k++) begin
      a = AW'('h20 + 4 * k);
      e = model_read(a);
      axi_read(a, d, lat);
      checks++;
      if (d !== e || lat != 3) begin
        errors++; $display("FAIL tap_read k=%0d: rdata=%h lat=%0d, expected %h lat=3", k, d, lat, e);
      end
    end
    for (int i = 0; i < 8; i++) begin
      a = AW'('h20 + 4 * $urandom_range(NT - 1));
      d = $urandom;
      axi_write(a, d, model_write(a, d), lat);
      a = AW'('h20 + 4 * $urandom_range(NT - 1));
      e = model_read(a);
      axi_read(a, d, lat);
      checks++;
      if (d !== e) begin
        errors++; $display("FAIL tap_rand addr=%h: rdata=%h, expected %h", a, d, e);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [AW-1:0] addrs [6];
    logic [31:0] d, e;
    int lat;
    addrs = '{12'h004, 12'h00C, 12'h014, 12'h01C, 12'h04C, 12'hFFC};
    foreach (addrs[i]) begin
      d = $urandom;
      axi_write(addrs[i], d, model_write(addrs[i], d), lat);
      e = model_read(addrs[i]);
      axi_read(addrs[i], d, lat);
      checks++;
      if (d !== e || data_length !== m_len) begin
        errors++;
        $display("FAIL unmapped addr=%h: rdata=%h data_length=%h, expected %h and %h",
                 addrs[i], d, data_length, e, m_len);
      end
    end
  endtask

  task automatic test_ap_ctrl();
    logic [31:0] d, e, v;
    int lat, s0;
    s0 = start_seen;
    axi_write(12'h000, 32'h1, model_write(12'h000, 32'h1), lat);
    checks++;
    if (start_seen != s0 + 1) begin
      errors++; $display("FAIL start_count: pulses=%0d, expected 1", start_seen - s0);
    end
    e = model_read(12'h000);
    axi_read(12'h000, d, lat);
    checks++;
    if (d !== e) begin errors++; $display("FAIL busy_status: rdata=%h, expected %h", d, e); end

    axi_write(12'h024, 32'h55, model_write(12'h024, 32'h55), lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL busy_tap_ack: lat=%0d, expected 1", lat); end
    e = model_read(12'h024);
    axi_read(12'h024, d, lat);
    checks++;
    if (d !== e) begin errors++; $display("FAIL busy_tap_read: rdata=%h, expected %h", d, e); end
    v = $urandom;
    axi_write(12'h010, v, model_write(12'h010, v), lat);
    e = model_read(12'h010);
    axi_read(12'h010, d, lat);
    checks++;
    if (d !== e || data_length !== m_len) begin
      errors++;
      $display("FAIL busy_len: rdata=%h data_length=%h, expected %h and %h", d, data_length, e, m_len);
    end
    s0 = start_seen;
    axi_write(12'h000, 32'h1, model_write(12'h000, 32'h1), lat);
    checks++;
    if (start_seen != s0) begin
      errors++; $display("FAIL busy_start: pulses=%0d, expected 0", start_seen - s0);
    end

    // Completion lands in the same cycle the status read clears done
    e = model_read(12'h000);
    fork
      axi_read(12'h000, d, lat);
      begin
        repeat (2) @(posedge clk);
        #1 ap_done_i = 1'b1;
        @(posedge clk); #1 ap_done_i = 1'b0;
      end
    join
    m_done = 1'b1; m_idle = 1'b1;
    checks++;
    if (d !== e) begin errors++; $display("FAIL race_status: rdata=%h, expected %h", d, e); end
    for (int i = 0; i < 2; i++) begin
      e = model_read(12'h000);
      axi_read(12'h000, d, lat);
      checks++;
      if (d !== e) begin errors++; $display("FAIL done_status#%0d: rdata=%h, expected %h", i, d, e); end
    end
    e = model_read(12'h024);
    axi_read(12'h024, d, lat);
    checks++;
    if (d !== e) begin errors++; $display("FAIL tap_kept: rdata=%h, expected %h", d, e); end
  endtask

  task automatic test_conflict();
    logic [AW-1:0] a;
    logic [31:0] v, d, e;
    int wl, rl;
    for (int i = 0; i < 3; i++) begin
      a = AW'('h20 + 4 * $urandom_range(NT - 1));
      v = $urandom;
      void'(model_write(a, v));
      e = model_read(a);
      fork
        axi_write(a, v, 1'b0, wl);
        axi_read(a, d, rl);
      join
      checks++;
      if (wl != 1 || rl != 4 || d !== e) begin
        errors++;
        $display("FAIL conflict addr=%h: wlat=%0d rlat=%0d rdata=%h, expected 1, 4, %h", a, wl, rl, d, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [31:0] d, e;
    int lat, sel;
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(9);
      if (sel < 6)      a = AW'('h20 + 4 * $urandom_range(NT - 1));
      else if (sel < 8) a = 12'h010;
      else              a = AW'(4 * $urandom_range(1023));
      if (a == 12'h000) a = 12'h008;
      if ($urandom_range(1) == 0) begin
        d = $urandom;
        axi_write(a, d, model_write(a, d), lat);
        checks++;
        if (data_length !== m_len) begin
          errors++; $display("FAIL b2b_len addr=%h: data_length=%h, expected %h", a, data_length, m_len);
        end
      end else begin
        e = model_read(a);
        axi_read(a, d, lat);
        checks++;
        if (d !== e || lat != 3) begin
          errors++; $display("FAIL b2b_read addr=%h: rdata=%h lat=%0d, expected %h lat=3", a, d, lat, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d, e;
    int lat, n;
    axi_write(12'h000, 32'h1, model_write(12'h000, 32'h1), lat);
    araddr = 12'h010; arvalid = 1'b1; n = 0;
    do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
    @(posedge clk); #1; arvalid = 1'b0;
    while (!rvalid && n < 25) begin @(posedge clk); #1; n++; end
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("FAIL mid_read_setup: rvalid=%b, expected 1", rvalid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || rdata !== '0 || data_length !== '0) begin
      errors++;
      $display("FAIL mid_reset: rvalid=%b arready=%b rdata=%h data_length=%h, expected all 0",
               rvalid, arready, rdata, data_length);
    end
    m_idle = 1'b1; m_done = 1'b0; m_len = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    e = model_read(12'h000);
    axi_read(12'h000, d, lat);
    checks++;
    if (d !== e || lat != 3) begin
      errors++; $display("FAIL post_reset_status: rdata=%h lat=%0d, expected %h lat=3", d, lat, e);
    end
    e = model_read(12'h020);
    axi_read(12'h020, d, lat);
    checks++;
    if (d !== e) begin errors++; $display("FAIL post_reset_tap: rdata=%h, expected %h", d, e); end
  endtask

  initial begin
    foreach (m_taps[i]) m_taps[i] = '0;
    foreach (ram[i]) ram[i] = '0;
    test_reset();
`ifdef AXIL_VALID_DROP_EN
    test_hold_valids();
`endif
    test_data_length();
    test_taps();
    test_unmapped();
    test_ap_ctrl();
    test_conflict();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
